// File: rtl/light_conflict_monitor_if.sv
// rtl/light_conflict_monitor_if.sv - encoded light bus in, decoded lamp and fault status out
interface light_conflict_monitor_if;
  logic [1:0] la;
  logic [1:0] lb;
  logic       clear_fault;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  modport master (
    output la, lb, clear_fault,
    input  lamp_a, lamp_b, fault, fault_code, fault_count
  );

  modport slave (
    input  la, lb, clear_fault,
    output lamp_a, lamp_b, fault, fault_code, fault_count
  );
endinterface

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - light bus safety monitor with latched flashing-red fault
// Optional yellow watchdog (fault code 6) enabled by defining LCM_YELLOW_WDOG_EN.
module light_conflict_monitor #(
  parameter int MIN_YELLOW = 5,
  parameter int MAX_YELLOW = 32,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  light_conflict_monitor_if.slave bus
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;

  localparam logic [1:0]       C_RED   = 2'b00;
  localparam logic [1:0]       C_YEL   = 2'b01;
  localparam logic [1:0]       C_GRN   = 2'b10;
  localparam logic [1:0]       C_BAD   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               FL_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLASH_HALF - 1);

  if (MIN_YELLOW < 1 || MAX_YELLOW <= MIN_YELLOW || FLASH_HALF < 1) begin : g_bad_params
    $error("light_conflict_monitor: inconsistent timing parameters");
  end

  state_t           state_q, state_d;
  logic [1:0]       prev_la_q, prev_la_d, prev_lb_q, prev_lb_d;
  logic [CNT_W-1:0] ycnt_a_q, ycnt_a_d, ycnt_b_q, ycnt_b_d;
  logic [CNT_W-1:0] ycnt_a_nx, ycnt_b_nx;
  logic [FL_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic             flash_on_q, flash_on_d;
  logic [2:0]       lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic [2:0]       code;
  logic             wdog_hit;

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      C_RED:   decode = 3'b100;
      C_YEL:   decode = 3'b010;
      C_GRN:   decode = 3'b001;
      default: decode = 3'b000;
    endcase
  endfunction

  // Hold, R->G, G->Y and Y->R are the only legal steps.
  function automatic logic bad_step(input logic [1:0] p, input logic [1:0] c);
    bad_step = (p == C_GRN && c == C_RED) ||
               (p == C_YEL && c == C_GRN) ||
               (p == C_RED && c == C_YEL);
  endfunction

  assign ycnt_a_nx = (bus.la != C_YEL) ? '0 :
                     (ycnt_a_q == CNT_MAX) ? ycnt_a_q : ycnt_a_q + 1'b1;
  assign ycnt_b_nx = (bus.lb != C_YEL) ? '0 :
                     (ycnt_b_q == CNT_MAX) ? ycnt_b_q : ycnt_b_q + 1'b1;

`ifdef LCM_YELLOW_WDOG_EN
  if ((2 ** CNT_W) - 1 < MAX_YELLOW) begin : g_bad_wdog
    $error("light_conflict_monitor: CNT_W too narrow for MAX_YELLOW");
  end
  // Fires on the sample that brings a direction's yellow run to MAX_YELLOW.
  assign wdog_hit = (bus.la == C_YEL && int'(ycnt_a_q) >= MAX_YELLOW - 1) ||
                    (bus.lb == C_YEL && int'(ycnt_b_q) >= MAX_YELLOW - 1);
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    code = 3'd0;
    if (bus.la == C_BAD || bus.lb == C_BAD) begin
      code = 3'd1;
    end else if (bus.la != C_RED && bus.lb != C_RED) begin
      code = 3'd2;
    end else if (state_q == ST_RUN) begin
      if (bad_step(prev_la_q, bus.la)) begin
        code = 3'd3;
      end else if (bad_step(prev_lb_q, bus.lb)) begin
        code = 3'd4;
      end else if ((prev_la_q == C_YEL && bus.la == C_RED && int'(ycnt_a_q) < MIN_YELLOW) ||
                   (prev_lb_q == C_YEL && bus.lb == C_RED && int'(ycnt_b_q) < MIN_YELLOW)) begin
        code = 3'd5;
      end else if (wdog_hit) begin
        code = 3'd6;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    prev_la_d     = bus.la;
    prev_lb_d     = bus.lb;
    ycnt_a_d      = ycnt_a_q;
    ycnt_b_d      = ycnt_b_q;
    flash_cnt_d   = flash_cnt_q;
    flash_on_d    = flash_on_q;
    lamp_a_d      = lamp_a_q;
    lamp_b_d      = lamp_b_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    fault_count_d = fault_count_q;
    case (state_q)
      ST_INIT, ST_RUN: begin
        state_d  = ST_RUN;
        ycnt_a_d = ycnt_a_nx;
        ycnt_b_d = ycnt_b_nx;
        lamp_a_d = decode(bus.la);
        lamp_b_d = decode(bus.lb);
        if (code != 3'd0) begin
          state_d       = ST_FAULT;
          fault_d       = 1'b1;
          fault_code_d  = code;
          fault_count_d = (fault_count_q == 8'hFF) ? fault_count_q : fault_count_q + 8'd1;
          flash_cnt_d   = '0;
          flash_on_d    = 1'b1;
          lamp_a_d      = 3'b100;
          lamp_b_d      = 3'b100;
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault && bus.la == C_RED && bus.lb == C_RED) begin
          state_d      = ST_INIT;
          fault_d      = 1'b0;
          fault_code_d = 3'd0;
          ycnt_a_d     = '0;
          ycnt_b_d     = '0;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b0;
          lamp_a_d     = 3'b100;
          lamp_b_d     = 3'b100;
        end else begin
          if (flash_cnt_q == FL_LAST) begin
            flash_cnt_d = '0;
            flash_on_d  = ~flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          lamp_a_d = {flash_on_d, 2'b00};
          lamp_b_d = {flash_on_d, 2'b00};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      prev_la_q     <= C_RED;
      prev_lb_q     <= C_RED;
      ycnt_a_q      <= '0;
      ycnt_b_q      <= '0;
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b0;
      lamp_a_q      <= 3'b100;
      lamp_b_q      <= 3'b100;
      fault_q       <= 1'b0;
      fault_code_q  <= 3'd0;
      fault_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      prev_la_q     <= prev_la_d;
      prev_lb_q     <= prev_lb_d;
      ycnt_a_q      <= ycnt_a_d;
      ycnt_b_q      <= ycnt_b_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_on_q    <= flash_on_d;
      lamp_a_q      <= lamp_a_d;
      lamp_b_q      <= lamp_b_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign bus.lamp_a      = lamp_a_q;
  assign bus.lamp_b      = lamp_b_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.fault_count = fault_count_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - directed-vector bench for light_conflict_monitor
module tb_light_conflict_monitor;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  light_conflict_monitor_if bus ();

  light_conflict_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] la_exp, input logic [2:0] lb_exp,
                         input logic f_exp, input logic [2:0] code_exp, input logic [7:0] cnt_exp);
    check({tag, ".lamp_a"}, 32'(bus.lamp_a), 32'(la_exp));
    check({tag, ".lamp_b"}, 32'(bus.lamp_b), 32'(lb_exp));
    check({tag, ".fault"}, 32'(bus.fault), 32'(f_exp));
    check({tag, ".code"}, 32'(bus.fault_code), 32'(code_exp));
    check({tag, ".count"}, 32'(bus.fault_count), 32'(cnt_exp));
  endtask

  task automatic cyc(input logic [1:0] a, input logic [1:0] b, input logic clr);
    bus.la          = a;
    bus.lb          = b;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input string tag, input logic [7:0] cnt_exp);
    cyc(2'b00, 2'b00, 1'b1);
    chk_out({tag, ".clr"}, 3'b100, 3'b100, 1'b0, 3'd0, cnt_exp);
    cyc(2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.la          = 2'b00;
    bus.lb          = 2'b00;
    bus.clear_fault = 1'b0;
    #1;
    chk_out("reset", 3'b100, 3'b100, 1'b0, 3'd0, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    cyc(2'b00, 2'b00, 1'b0);
    // Legal cycle: A green/yellow/red with B red, then B the same.
    for (int i = 0; i < 10; i++) cyc(2'b10, 2'b00, 1'b0);
    chk_out("a_green", 3'b001, 3'b100, 1'b0, 3'd0, 8'd0);
    for (int i = 0; i < 6; i++) cyc(2'b01, 2'b00, 1'b0);
    chk_out("a_yellow", 3'b010, 3'b100, 1'b0, 3'd0, 8'd0);
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("a_red", 3'b100, 3'b100, 1'b0, 3'd0, 8'd0);
    for (int i = 0; i < 10; i++) cyc(2'b00, 2'b10, 1'b0);
    chk_out("b_green", 3'b100, 3'b001, 1'b0, 3'd0, 8'd0);
    for (int i = 0; i < 6; i++) cyc(2'b00, 2'b01, 1'b0);
    chk_out("b_yellow", 3'b100, 3'b010, 1'b0, 3'd0, 8'd0);
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("b_red", 3'b100, 3'b100, 1'b0, 3'd0, 8'd0);

    // Conflicting greens, then the flash pattern.
    cyc(2'b10, 2'b10, 1'b0);
    chk_out("conflict", 3'b100, 3'b100, 1'b1, 3'd2, 8'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 2'b00, 1'b0);
      check("flash_on", 32'(bus.lamp_a), 32'(3'b100));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(2'b00, 2'b00, 1'b0);
      check("flash_off_a", 32'(bus.lamp_a), 32'(3'b000));
      check("flash_off_b", 32'(bus.lamp_b), 32'(3'b000));
    end
    cyc(2'b01, 2'b00, 1'b1);
    chk_out("clear_nonred", 3'b100, 3'b100, 1'b1, 3'd2, 8'd1);
    do_clear("conflict", 8'd1);
    cyc(2'b00, 2'b00, 1'b1);
    chk_out("clear_in_run", 3'b100, 3'b100, 1'b0, 3'd0, 8'd1);

    // Short yellow (4 cycles) faults; 5 cycles is legal.
    cyc(2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("short_yel", 3'b100, 3'b100, 1'b1, 3'd5, 8'd2);
    do_clear("short_yel", 8'd2);
    cyc(2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("min_yel", 3'b100, 3'b100, 1'b0, 3'd0, 8'd2);

    cyc(2'b11, 2'b10, 1'b0);
    chk_out("simul", 3'b100, 3'b100, 1'b1, 3'd1, 8'd3);
    do_clear("simul", 8'd3);

    cyc(2'b10, 2'b00, 1'b0);
    check("g_before_r", 32'(bus.lamp_a), 32'(3'b001));
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("a_g_to_r", 3'b100, 3'b100, 1'b1, 3'd3, 8'd4);
    do_clear("a_g_to_r", 8'd4);

    cyc(2'b00, 2'b01, 1'b0);
    chk_out("b_r_to_y", 3'b100, 3'b100, 1'b1, 3'd4, 8'd5);

    // Violation in the INIT cycle right after a clear.
    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b10, 2'b10, 1'b0);
    chk_out("init_viol", 3'b100, 3'b100, 1'b1, 3'd2, 8'd6);
    do_clear("init_viol", 8'd6);

    cyc(2'b10, 2'b00, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      cyc(2'b01, 2'b00, 1'b0);
      if (i == 31) check("wdog_31", 32'(bus.fault), 32'd0);
    end
`ifdef LCM_YELLOW_WDOG_EN
    chk_out("wdog", 3'b100, 3'b100, 1'b1, 3'd6, 8'd7);
    do_clear("wdog", 8'd7);
`else
    chk_out("long_yel", 3'b010, 3'b100, 1'b0, 3'd0, 8'd6);
    for (int i = 0; i < 8; i++) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    chk_out("long_yel_r", 3'b100, 3'b100, 1'b0, 3'd0, 8'd6);
`endif

    // Asynchronous reset while in FAULT.
    cyc(2'b10, 2'b10, 1'b0);
    check("pre_reset_fault", 32'(bus.fault), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 3'b100, 3'b100, 1'b0, 3'd0, 8'd0);
    #2;
    reset = 1'b0;
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b10, 2'b00, 1'b0);
    chk_out("post_reset", 3'b001, 3'b100, 1'b0, 3'd0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
